seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-cathode 7-segment digits sharing one seg bus.
//  Captures a packed hex word, walks the digits one at a time and drives the shared segment lines.
//  Each digit is decoded through a single hex decoder instance. Active-low anode strobes select the lit digit.
//  Inserts a dark guard interval between digits to kill ghosting. Sits between the CPU/datapath result regs and the board pins.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; digit k = value[4k+3:4k], digit 0 least significant, on an_n[0]
//  SCAN_DIV      50000  clk cycles each digit is lit (>=1)
//  GUARD_CYCLES  500    clk cycles all anodes dark between digits (0 = no guard state)
// PORTS
//  clk         in   1             system clock, rising edge
//  reset       in   1             asynchronous, active-high reset
//  en          in   1             1 = scan, 0 = display dark
//  load        in   1             capture value/dp_in/blank into pending regs this edge
//  value       in   4*NUM_DIGITS  packed hex nibbles
//  dp_in       in   NUM_DIGITS    decimal point per digit
//  blank       in   NUM_DIGITS    1 = force digit dark (seg=0, dp=0)
//  seg         out  7             segments {g,f,e,d,c,b,a}, active-high
//  dp          out  1             decimal point, active-high
//  an_n        out  NUM_DIGITS    digit anode strobes, active-low, at most one low
//  frame_done  out  1             one-cycle pulse when last digit's ON period ends
// BEHAVIOUR
//  Reset (async): state IDLE, idx=0, prescaler=0, pending/display regs=0, seg=0, dp=0, an_n=all 1, frame_done=0.
//  States:
//   - IDLE: an_n all 1. en=1 -> GUARD (or ON if GUARD_CYCLES==0), idx=0.
//   - GUARD: all dark for GUARD_CYCLES cycles -> ON.
//   - ON: an_n[idx]=0 for SCAN_DIV cycles. Then idx = (idx==NUM_DIGITS-1) ? 0 : idx+1 and go to GUARD/ON.
//   - Leaving ON with idx==NUM_DIGITS-1 pulses frame_done for exactly one cycle.
//   - en=0 in any state -> IDLE next edge: idx and prescaler cleared, frame_done not pulsed. Re-enable restarts at digit 0.
//  Timing: frame period = NUM_DIGITS*(SCAN_DIV+GUARD_CYCLES) cycles. All outputs registered: 1-cycle latency from state/idx.
//  Capture: load=1 -> pending <= {value,dp_in,blank}.
//   - On entry to digit 0 (frame start), display <= pending, so no mid-frame tearing.
//   - If load coincides with the frame-start edge, the new value is used directly for that frame.
//  Decode: seg = decode(display nibble[idx]) and dp = display dp[idx], unless blank[idx] -> seg=0, dp=0.
//   - Blanked digits still consume their ON slot (an_n still strobed), so brightness stays constant.
//  Counters: prescaler width $clog2(max(SCAN_DIV,GUARD_CYCLES)+1); idx width $clog2(NUM_DIGITS), min 1. No overflow past terminal count.
// CONFIGURATION
//  `LEADING_ZERO_BLANK_EN defined: a digit whose nibble and every higher nibble are 0 is blanked as if blank=1.
//   - Digit 0 is never auto-blanked, so value 0 shows "0".
//   - Evaluated on display regs. OR-ed with blank.
//  Undefined: all digits shown unless blank set; no extra logic.
// STRUCTURE
//  Package seg7_pkg: state encoding localparams (S_IDLE, S_GUARD, S_ON), SEG_BLANK=7'b0000000.
//  One sub-module: seg7_decode (4-bit hex -> 7-bit seg, combinational), instantiated once on the muxed nibble.
//  FSM, prescaler, idx counter, pending/display regs and output regs live in seg7_scan_ctrl.
// TESTING (NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2)
//  1. Reset asserted asynchronously mid-scan -> same cycle seg=0, dp=0, an_n=4'b1111, frame_done=0.
//  2. load value=16'h12AF, en=1 -> after 2 guard cycles an_n=4'b1110, seg=7'b1110001 for 8 cycles.
//     Then 2 dark cycles, then an_n=4'b1101 with seg=7'b1110111. frame_done pulses every 40 cycles.
//  3. Frame showing 16'h12AF, load 16'h3333 while idx=2 -> digits 2,3 still show 2,1.
//     Next frame digit 0 shows seg=7'b1001111.
//  4. blank=4'b0100 -> while an_n=4'b1011, seg=0 and dp=0. Slot length is still 8 cycles.
//  5. en dropped while idx=1 in ON -> an_n=4'b1111 one cycle later, no frame_done.
//     Re-assert en -> first lit digit is an_n=4'b1110 after 2 guard cycles.
//  6. `LEADING_ZERO_BLANK_EN, value=16'h0050 -> digits 3,2 dark, digit 1 shows 5, digit 0 shows seg=7'b0111111.
//     Then value=16'h0000 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_t;

    // Segment pattern driven whenever no digit is lit or a digit is blanked
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Larger of two integers, used to size the shared prescaler
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to 7-segment pattern {g,f,e,d,c,b,a}, active-high, combinational.
module seg7_decode (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Standard hex glyphs; lower-case b and d to keep them distinct from 8 and 0
    always_comb begin
        seg_o = 7'b0000000;
        unique case (nibble_i)
            4'h0: seg_o = 7'b0111111;
            4'h1: seg_o = 7'b0000110;
            4'h2: seg_o = 7'b1011011;
            4'h3: seg_o = 7'b1001111;
            4'h4: seg_o = 7'b1100110;
            4'h5: seg_o = 7'b1101101;
            4'h6: seg_o = 7'b1111101;
            4'h7: seg_o = 7'b0000111;
            4'h8: seg_o = 7'b1111111;
            4'h9: seg_o = 7'b1101111;
            4'hA: seg_o = 7'b1110111;
            4'hB: seg_o = 7'b1111100;
            4'hC: seg_o = 7'b0111001;
            4'hD: seg_o = 7'b1011110;
            4'hE: seg_o = 7'b1111001;
            4'hF: seg_o = 7'b1110001;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-cathode 7-segment digits on a shared seg bus.
// Optional build macro: LEADING_ZERO_BLANK_EN -- auto-blank leading zero digits (digit 0 never blanked).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | scanning disabled, all anodes dark, idx/prescaler at zero
// S_GUARD | dark gap between digits to suppress ghosting
// S_ON    | digit idx lit for SCAN_DIV cycles
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(max2(SCAN_DIV, GUARD_CYCLES) + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam bit HAS_GUARD = (GUARD_CYCLES > 0);
    localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fd_d;
    logic                    frame_start;

    logic [4*NUM_DIGITS-1:0] pend_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q, disp_blank_q;

    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
    logic                    blank_eff;

    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_n_q;
    logic                    fd_q;

    // FSM state, digit index and shared down-counting prescaler
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: dropping en always returns to IDLE with counters cleared
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    idx_d = '0;
                    if (HAS_GUARD) begin
                        state_d = S_GUARD;
                        cnt_d   = GUARD_LOAD;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = SCAN_LOAD;
                    end
                end
                S_GUARD: begin
                    if (cnt_q == '0) begin
                        state_d = S_ON;
                        cnt_d   = SCAN_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (cnt_q == '0) begin
                        fd_d  = (idx_q == LAST_IDX);
                        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        if (HAS_GUARD) begin
                            state_d = S_GUARD;
                            cnt_d   = GUARD_LOAD;
                        end else begin
                            state_d = S_ON;
                            cnt_d   = SCAN_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A new ON slot for digit 0 begins: either entering ON, or ON wrapping with no guard
    assign frame_start = (state_d == S_ON) && (idx_d == '0) &&
                         ((state_q != S_ON) || (cnt_q == '0));

    // Pending capture on load; display snapshot only at frame start to avoid tearing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
        end else begin
            if (load) begin
                pend_val_q   <= value;
                pend_dp_q    <= dp_in;
                pend_blank_q <= blank;
            end
            if (frame_start) begin
                disp_val_q   <= load ? value : pend_val_q;
                disp_dp_q    <= load ? dp_in : pend_dp_q;
                disp_blank_q <= load ? blank : pend_blank_q;
            end
        end
    end

    assign cur_nibble = disp_val_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lzb;
    logic                  hi_zero;

    // Digit k is a leading zero when it and every higher nibble are zero; digit 0 excluded
    always_comb begin
        lzb     = '0;
        hi_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            hi_zero = hi_zero && (disp_val_q[4*k +: 4] == 4'h0);
            lzb[k]  = hi_zero;
        end
    end

    assign blank_eff = disp_blank_q[idx_q] | lzb[idx_q];
`else
    assign blank_eff = disp_blank_q[idx_q];
`endif

    // Registered pin drivers; blanked digits keep their anode strobe for even brightness
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b0;
            an_n_q <= '1;
            fd_q   <= 1'b0;
        end else begin
            fd_q <= fd_d;
            if (state_q == S_ON) begin
                an_n_q <= ~(ONE_HOT0 << idx_q);
                seg_q  <= blank_eff ? SEG_BLANK : dec_seg;
                dp_q   <= !blank_eff && disp_dp_q[idx_q];
            end else begin
                an_n_q <= '1;
                seg_q  <= SEG_BLANK;
                dp_q   <= 1'b0;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an_n       = an_n_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2).
// Optional build macro: LEADING_ZERO_BLANK_EN enables the leading-zero scenario.
module tb_seg7_scan_ctrl;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_F = 7'b1110001;
    localparam logic [6:0] SEG_X = 7'b0000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an_n;
    logic        frame_done;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         len;   // 0 = slot may be cut short, length not checked
    } slot_t;

    slot_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (8),
        .GUARD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank      (blank),
        .seg        (seg),
        .dp         (dp),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] an, input logic [6:0] s, input logic d, input int len);
        slot_t e;
        e.an  = an;
        e.seg = s;
        e.dp  = d;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dps);
        push(4'b1110, s0, dps[0], 8);
        push(4'b1101, s1, dps[1], 8);
        push(4'b1011, s2, dps[2], 8);
        push(4'b0111, s3, dps[3], 8);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input int n);
        int seen = 0;
        int k = 0;
        while (seen < n && k < 400) begin
            @(negedge clk);
            k++;
            if (frame_done) seen++;
        end
        chk("wait_frame_done", seen, n);
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int found = 0;
        int k = 0;
        while (found == 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (an_n == pat) found = 1;
        end
        chk("wait_anode", found, 1);
    endtask

    // negedges from the enabling drive to the first lit digit: IDLE, GUARD x2, ON, then output reg
    task automatic measure_latency(input string name);
        int k = 0;
        int got = 0;
        while (got == 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (an_n != 4'hF) got = 1;
        end
        chk(name, k, 5);
    endtask

    task automatic end_phase(input string name);
        tick();
        en = 1'b0;
        repeat (4) tick();
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: collapses each lit interval into one slot and scores it against the queue
    initial begin
        int         cyc = 0;
        int         fd_last = 0;
        bit         fd_valid = 0;
        bit         in_slot = 0;
        bit         steady = 0;
        int         len = 0;
        logic [3:0] cur_an = '1;
        logic [6:0] cur_seg = '0;
        logic       cur_dp = 0;
        slot_t      e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                in_slot  = 0;
                fd_valid = 0;
            end else begin
                if (!en) fd_valid = 0;
                if (frame_done) begin
                    if (fd_valid) chk("frame_period", cyc - fd_last, 40);
                    fd_valid = 1;
                    fd_last  = cyc;
                end
                if (an_n != 4'hF) begin
                    if (!in_slot) begin
                        in_slot = 1;
                        cur_an  = an_n;
                        cur_seg = seg;
                        cur_dp  = dp;
                        len     = 1;
                        steady  = 1;
                    end else begin
                        len++;
                        if (an_n != cur_an || seg != cur_seg || dp != cur_dp) steady = 0;
                    end
                end else if (in_slot) begin
                    in_slot = 0;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_slot: an_n=%b seg=%b dp=%b, expected no lit digit", cur_an, cur_seg, cur_dp);
                    end else begin
                        e = exp_q.pop_front();
                        chk("slot_an_n", cur_an, e.an);
                        chk("slot_seg", cur_seg, e.seg);
                        chk("slot_dp", cur_dp, e.dp);
                        if (e.len != 0) chk("slot_len", len, e.len);
                        chk("slot_steady", steady, 1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_fd;
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        value = '0;
        dp_in = '0;
        blank = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", seg, 7'b0);
        chk("rst_dp", dp, 1'b0);
        chk("rst_an_n", an_n, 4'hF);
        chk("rst_frame_done", frame_done, 1'b0);
        reset = 1'b0;
        repeat (2) tick();

        // 12AF over three frames; 3333 loaded mid-frame-2 appears only in frame 3
        push_frame(SEG_F, SEG_A, SEG_2, SEG_1, 4'b0000);
        push_frame(SEG_F, SEG_A, SEG_2, SEG_1, 4'b0000);
        push_frame(SEG_3, SEG_3, SEG_3, SEG_3, 4'b0000);
        value = 16'h12AF;
        load  = 1'b1;
        en    = 1'b1;
        measure_latency("enable_latency");
        tick();
        load = 1'b0;
        wait_fd(1);
        wait_an(4'b1011);
        tick();
        value = 16'h3333;
        load  = 1'b1;
        tick();
        load = 1'b0;
        wait_fd(2);
        end_phase("drain_basic");

        // blank digit 2, dp on 1 and 2; load lands exactly on the frame-start edge
        push_frame(SEG_F, SEG_A, SEG_X, SEG_1, 4'b0010);
        value = 16'h12AF;
        dp_in = 4'b0110;
        blank = 4'b0100;
        en    = 1'b1;
        tick();
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_fd(1);
        end_phase("drain_blank");

        // disable mid digit 1, then re-enable from digit 0
        dp_in = '0;
        blank = '0;
        push(4'b1110, SEG_F, 1'b0, 8);
        push(4'b1101, SEG_A, 1'b0, 0);
        load = 1'b1;
        en   = 1'b1;
        tick();
        load = 1'b0;
        wait_an(4'b1101);
        tick();
        tick();
        en = 1'b0;
        saw_fd = 0;
        repeat (2) begin
            @(negedge clk);
            if (frame_done) saw_fd = 1;
        end
        @(negedge clk);
        chk("disable_dark", an_n, 4'hF);
        repeat (5) begin
            @(negedge clk);
            if (frame_done) saw_fd = 1;
        end
        chk("disable_no_frame_done", saw_fd, 0);
        push_frame(SEG_F, SEG_A, SEG_2, SEG_1, 4'b0000);
        tick();
        en = 1'b1;
        measure_latency("reenable_latency");
        wait_fd(1);
        end_phase("drain_reenable");

`ifdef LEADING_ZERO_BLANK_EN
        // leading zeros dark, digit 0 always shown
        push_frame(SEG_0, SEG_5, SEG_X, SEG_X, 4'b0000);
        push_frame(SEG_0, SEG_X, SEG_X, SEG_X, 4'b0000);
        value = 16'h0050;
        load  = 1'b1;
        en    = 1'b1;
        tick();
        load = 1'b0;
        wait_an(4'b1011);
        tick();
        value = 16'h0000;
        load  = 1'b1;
        tick();
        load = 1'b0;
        wait_fd(2);
        end_phase("drain_lzb");
`endif

        // asynchronous reset while digit 1 is lit
        push(4'b1110, SEG_F, 1'b0, 8);
        value = 16'h12AF;
        load  = 1'b1;
        en    = 1'b1;
        tick();
        load = 1'b0;
        wait_an(4'b1101);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_seg", seg, 7'b0);
        chk("async_rst_dp", dp, 1'b0);
        chk("async_rst_an_n", an_n, 4'hF);
        chk("async_rst_frame_done", frame_done, 1'b0);
        en = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("drain_reset", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
